// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: state encoding and read-latency bounds shared by the mem_bist blocks.
package mem_bist_pkg;
    typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FIN} state_t;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
endpackage

// File: rtl/mem_bist_dly.sv
// mem_bist_dly: fixed-depth shift register carrying read context until memory data returns.
module mem_bist_dly #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= '0;
        else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end

    assign q = sr[DEPTH-1];
endmodule

// File: rtl/mem_bist_16kb.sv
// mem_bist_16kb: write/read/write-inverse/read memory BIST with pipelined compare.
// Define MEM_BIST_FAIL_LOG_EN to capture the address and data of the first mismatch.
module mem_bist_16kb
    import mem_bist_pkg::*;
#(
    parameter int                ADDR_W = 14,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(8'hA5),
    parameter int                RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam int CW  = ADDR_W + 3;
    localparam int D   = 1 << ADDR_W;
    localparam int DW  = 1 + ADDR_W + DATA_W;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ SEED;
    endfunction

    state_t            state, nxt_state;
    logic [CW-1:0]     cnt, nxt_cnt;
    logic              last_wr, last_rd, nxt_wr, nxt_sweep, rd_v, dly_v, mism;
    logic [DATA_W-1:0] rd_exp, dly_exp;
    logic [ADDR_W-1:0] dly_addr;
    logic [DW-1:0]     dly_q;

    assign last_wr   = cnt == CW'(D - 1);
    assign last_rd   = cnt == CW'(D + LAT - 1);
    assign nxt_wr    = nxt_state == WR0 || nxt_state == WR1;
    assign nxt_sweep = nxt_state != IDLE && nxt_state != FIN && nxt_cnt < CW'(D);
    assign rd_v      = (state == RD0 || state == RD1) && cnt < CW'(D);
    assign rd_exp    = state == RD0 ? pat(cnt[ADDR_W-1:0]) : ~pat(cnt[ADDR_W-1:0]);
    assign {dly_v, dly_addr, dly_exp} = dly_q;
    assign mism      = dly_v && mem_rdata != dly_exp;

    // Read phases run LAT extra cycles so the last issued read is compared before moving on.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 1'b1;
        case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (start) nxt_state = WR0;
            end
            WR0: if (last_wr) begin nxt_state = RD0; nxt_cnt = '0; end
            RD0: if (last_rd) begin nxt_state = WR1; nxt_cnt = '0; end
            WR1: if (last_wr) begin nxt_state = RD1; nxt_cnt = '0; end
            RD1: if (last_rd) begin nxt_state = FIN; nxt_cnt = '0; end
            default: begin nxt_state = IDLE; nxt_cnt = '0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            busy      <= nxt_state != IDLE;
            done      <= nxt_state == FIN;
            mem_we    <= nxt_wr;
            mem_addr  <= nxt_sweep ? nxt_cnt[ADDR_W-1:0] : '0;
            mem_wdata <= !nxt_wr ? '0 : nxt_state == WR0 ? pat(nxt_cnt[ADDR_W-1:0]) : ~pat(nxt_cnt[ADDR_W-1:0]);
            if (state == FIN) pass <= err_cnt == '0;
            if (state == IDLE && start) err_cnt <= '0;
            else if (mism && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end

    mem_bist_dly #(.DEPTH(LAT), .WIDTH(DW)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({rd_v, cnt[ADDR_W-1:0], rd_exp}),
        .q     (dly_q)
    );

`ifdef MEM_BIST_FAIL_LOG_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            fail_addr <= '0;
            fail_data <= '0;
        end else if (state == IDLE && start) begin
            fail_addr <= '0;
            fail_data <= '0;
        end else if (mism && err_cnt == '0) begin
            fail_addr <= dly_addr;
            fail_data <= mem_rdata;
        end
`else
    logic unused_dly_addr;
    assign unused_dly_addr = ^dly_addr;
    assign fail_addr = '0;
    assign fail_data = '0;
`endif
endmodule

// File: tb/tb_mem_bist_16kb.sv
// tb_mem_bist_16kb: randomized stuck-at faults, reference model scoreboard, two read latencies.
module tb_mem_bist_16kb;
    localparam int D = 16;
    localparam logic [7:0] SEED = 8'hA5;

    typedef struct {
        bit         abort;
        int         blen;
        bit         pass;
        int         err;
        logic [3:0] fa;
        logic [7:0] fd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a = 1'b1, start_a = 1'b0, busy_a, done_a, pass_a, we_a;
    logic rst_n_b = 1'b1, start_b = 1'b0, busy_b, done_b, pass_b, we_b;
    logic [15:0] err_a, err_b;
    logic [3:0]  fa_a, fa_b, addr_a, addr_b;
    logic [7:0]  fd_a, fd_b, wd_a, wd_b, rd_a, rd_b;

    mem_bist_16kb #(.ADDR_W(4), .DATA_W(8), .SEED(8'hA5), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .fail_addr(fa_a), .fail_data(fd_a), .mem_addr(addr_a), .mem_wdata(wd_a),
        .mem_we(we_a), .mem_rdata(rd_a));

    mem_bist_16kb #(.ADDR_W(4), .DATA_W(8), .SEED(8'hA5), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .fail_addr(fa_b), .fail_data(fd_b), .mem_addr(addr_b), .mem_wdata(wd_b),
        .mem_we(we_b), .mem_rdata(rd_b));

    // Memories with per-address stuck-at masks applied on read.
    logic [7:0] mem_a [D], sa1_a [D], sa0_a [D];
    logic [7:0] mem_b [D], sa1_b [D], sa0_b [D];
    logic [7:0] pb [3];

    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= wd_a;
        rd_a <= (mem_a[addr_a] | sa1_a[addr_a]) & ~sa0_a[addr_a];
        if (we_b) mem_b[addr_b] <= wd_b;
        pb[0] <= (mem_b[addr_b] | sa1_b[addr_b]) & ~sa0_b[addr_b];
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign rd_b = pb[2];

    int nchk = 0, nerr = 0;
    exp_t qa [$], qb [$];
    int blen_a = 0, dcnt_a = 0, runs_a = 0;
    int blen_b = 0, dcnt_b = 0, runs_b = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input bit b, input int lat);
        exp_t e;
        logic [7:0] w, r, s1, s0;
        e.abort = 0; e.blen = 2 * (2 * D + lat) + 1; e.err = 0; e.fa = 0; e.fd = 0;
        for (int ph = 0; ph < 2; ph++)
            for (int a = 0; a < D; a++) begin
                w  = 8'(a) ^ SEED;
                if (ph == 1) w = ~w;
                s1 = b ? sa1_b[a] : sa1_a[a];
                s0 = b ? sa0_b[a] : sa0_a[a];
                r  = (w | s1) & ~s0;
                if (r != w) begin
                    if (e.err == 0) begin e.fa = 4'(a); e.fd = r; end
                    if (e.err < 65535) e.err++;
                end
            end
        e.pass = e.err == 0;
`ifndef MEM_BIST_FAIL_LOG_EN
        e.fa = 0; e.fd = 0;
`endif
        return e;
    endfunction

    task automatic end_run(input bit b, input bit aborted, input int blen, input int dcnt);
        exp_t e;
        string tg = b ? "b" : "a";
        if (b ? qb.size() == 0 : qa.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL %s unexpected_run: got run of %0d busy cycles, expected none", tg, blen);
            return;
        end
        e = b ? qb.pop_front() : qa.pop_front();
        chk({tg, " aborted"}, aborted, e.abort);
        if (aborted) begin
            chk({tg, " busy_after_rst"}, b ? busy_b : busy_a, 0);
            chk({tg, " we_after_rst"}, b ? we_b : we_a, 0);
            chk({tg, " done_in_abort"}, dcnt, 0);
        end else begin
            chk({tg, " busy_len"}, blen, e.blen);
            chk({tg, " done_pulses"}, dcnt, 1);
            chk({tg, " pass"}, b ? pass_b : pass_a, e.pass);
            chk({tg, " err_cnt"}, b ? err_b : err_a, e.err);
            chk({tg, " fail_addr"}, b ? fa_b : fa_a, e.fa);
            chk({tg, " fail_data"}, b ? fd_b : fd_a, e.fd);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n_a) begin
            if (blen_a > 0) begin end_run(0, 1, blen_a, dcnt_a); runs_a++; end
            blen_a = 0; dcnt_a = 0;
        end else if (busy_a) begin
            blen_a++; dcnt_a += int'(done_a);
        end else if (blen_a > 0) begin
            end_run(0, 0, blen_a, dcnt_a); runs_a++; blen_a = 0; dcnt_a = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n_b) begin
            if (blen_b > 0) begin end_run(1, 1, blen_b, dcnt_b); runs_b++; end
            blen_b = 0; dcnt_b = 0;
        end else if (busy_b) begin
            blen_b++; dcnt_b += int'(done_b);
        end else if (blen_b > 0) begin
            end_run(1, 0, blen_b, dcnt_b); runs_b++; blen_b = 0; dcnt_b = 0;
        end
    end

    task automatic clear_faults(input bit b);
        for (int a = 0; a < D; a++)
            if (b) begin sa1_b[a] = 0; sa0_b[a] = 0; end
            else   begin sa1_a[a] = 0; sa0_a[a] = 0; end
    endtask

    task automatic rand_faults(input bit b);
        int k = $urandom_range(0, 3);
        clear_faults(b);
        for (int i = 0; i < k; i++) begin
            int a = $urandom_range(0, D - 1);
            logic [7:0] m = 8'(1) << $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                if (b) sa1_b[a] |= m; else sa1_a[a] |= m;
            end else begin
                if (b) sa0_b[a] |= m; else sa0_a[a] |= m;
            end
        end
    endtask

    task automatic pulse(input bit b);
        @(negedge clk);
        if (b) start_b = 1; else start_a = 1;
        @(negedge clk);
        start_a = 0; start_b = 0;
    endtask

    task automatic wait_runs(input bit b, input int target);
        int n = 0;
        while ((b ? runs_b : runs_a) < target && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) begin
            nchk++; nerr++;
            $display("FAIL %s run_timeout: runs %0d expected %0d", b ? "b" : "a", b ? runs_b : runs_a, target);
        end
    endtask

    task automatic run(input bit b);
        int t = (b ? runs_b : runs_a) + 1;
        if (b) qb.push_back(model(1, 3)); else qa.push_back(model(0, 1));
        pulse(b);
        wait_runs(b, t);
    endtask

    initial begin
        exp_t e;
        int t;
        clear_faults(0);
        clear_faults(1);
        #1 rst_n_a = 0; rst_n_b = 0;
        repeat (3) @(negedge clk);
        chk("rst busy", busy_a, 0);
        chk("rst done", done_a, 0);
        chk("rst pass", pass_a, 0);
        chk("rst err_cnt", err_a, 0);
        chk("rst fail_addr", fa_a, 0);
        chk("rst fail_data", fd_a, 0);
        chk("rst mem_addr", addr_a, 0);
        chk("rst mem_wdata", wd_a, 0);
        chk("rst mem_we", we_a, 0);
        rst_n_a = 1; rst_n_b = 1;

        run(0);
        sa1_a[5] = 8'h08;
        run(0);
        clear_faults(0);
        for (int a = 0; a < D; a++) sa0_a[a] = 8'hFF;
        run(0);
        clear_faults(0);

        // start re-pulsed mid-run must be ignored
        t = runs_a + 1;
        qa.push_back(model(0, 1));
        pulse(0);
        repeat (9) @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        wait_runs(0, t);

        // start held through FIN (ignored) into the following idle cycle (accepted)
        t = runs_a + 2;
        qa.push_back(model(0, 1));
        qa.push_back(model(0, 1));
        pulse(0);
        for (int n = 0; n < 300 && !done_a; n++) @(negedge clk);
        start_a = 1;
        repeat (2) @(negedge clk);
        start_a = 0;
        wait_runs(0, t);

        // reset at busy cycle 20 aborts the run
        t = runs_a + 1;
        e = model(0, 1);
        e.abort = 1;
        qa.push_back(e);
        pulse(0);
        repeat (19) @(negedge clk);
        #1 rst_n_a = 0;
        wait_runs(0, t);
        @(negedge clk);
        rst_n_a = 1;
        run(0);

        repeat (6) begin rand_faults(0); run(0); end
        clear_faults(0);

        run(1);
        repeat (3) begin rand_faults(1); run(1); end

        chk("a leftover_expected", qa.size(), 0);
        chk("b leftover_expected", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mem_bist_16kb.md
MEM_BIST_16KB -- requirements
Module: mem_bist_16kb

Interface
REQ-001 SHALL provide parameter ADDR_W, default 14, word-address width (2^ADDR_W words, 16KB at default).
REQ-002 SHALL provide parameter DATA_W, default 8, memory word width.
REQ-003 SHALL provide parameter SEED, default 8'hA5, pattern seed.
REQ-004 SHALL provide parameter RD_LAT, default 1, memory read latency in cycles (1..4).
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-006 SHALL have start input 1, single-cycle request to run the test.
REQ-007 SHALL have busy output 1, high while the test runs.
REQ-008 SHALL have done output 1, one-cycle pulse at completion.
REQ-009 SHALL have pass output 1, result of the last completed run; valid while idle.
REQ-010 SHALL have err_cnt output 16, saturating mismatch count.
REQ-011 SHALL have fail_addr output ADDR_W and fail_data output DATA_W, giving the address and read data of the first mismatch.
REQ-012 SHALL have mem_addr output ADDR_W, mem_wdata output DATA_W and mem_we output 1, driving the memory port.
REQ-013 SHALL have mem_rdata input DATA_W, memory read data, valid RD_LAT cycles after the address.

Function
REQ-014 SHALL implement FSM states IDLE, WR0, RD0, WR1, RD1, FIN.
- IDLE -> WR0 on start.
- WR0 -> RD0 -> WR1 -> RD1 -> FIN.
- FIN -> IDLE after one cycle.
REQ-015 SHALL sweep addresses 0..D-1 (D = 2^ADDR_W), one address per cycle, in each of WR0/WR1/RD0/RD1; the address counter wraps to 0 at each phase change.
REQ-016 SHALL write pat(a) = {a zero-extended/truncated to DATA_W} XOR SEED in WR0, and ~pat(a) in WR1.
REQ-017 SHALL hold mem_we high only in WR0/WR1; mem_wdata is 0 whenever mem_we is low.
REQ-018 SHALL pipeline reads: issue one address per cycle, carry the expected data and address through an RD_LAT-deep delay line, and compare against mem_rdata on arrival.
REQ-019 SHALL stay in RD0/RD1 for D+RD_LAT cycles, draining the pipeline before leaving.
REQ-020 SHALL hold busy high for exactly 2*(2D+RD_LAT)+1 cycles, starting the cycle after start is sampled; done pulses in the FIN cycle, and busy falls after FIN.
REQ-021 SHALL clear err_cnt on a start accepted in IDLE, and increment it per mismatch, saturating at 16'hFFFF.
REQ-022 SHALL update pass at FIN to (err_cnt==0) and hold it until the next FIN.
REQ-023 SHALL ignore start while busy, and ignore start in the FIN cycle.
REQ-024 SHALL accept a start asserted in the cycle after done.
REQ-025 SHALL NOT count a mismatch on the final drained read that occurs in the same cycle as the phase transition twice; each compare counts once.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force IDLE and drive the outputs to 0: busy, done, pass, err_cnt, fail_addr, fail_data, mem_addr, mem_wdata, mem_we.
REQ-027 SHALL, on reset mid-run, abort the run with no done pulse; a new start is required after reset release.

Configuration
REQ-028 SHALL, when macro MEM_BIST_FAIL_LOG_EN is defined, capture fail_addr/fail_data on the first mismatch of a run, hold them until the next accepted start, and clear them on start.
REQ-029 SHALL, when MEM_BIST_FAIL_LOG_EN is undefined, omit the capture registers and tie fail_addr/fail_data to 0; all other behaviour is unchanged.

Structure
REQ-030 SHALL place the FSM state encoding (3-bit) and the RD_LAT bounds in shared package mem_bist_pkg.
REQ-031 SHALL implement the expected-data/address delay line as sub-module mem_bist_dly (parameters DEPTH=RD_LAT and WIDTH; async active-low reset to 0).

Verification
REQ-032 Bench (ADDR_W=4, RD_LAT=1, fault-free sync-read memory model) SHALL check: start pulse -> busy for 67 cycles, one done pulse, pass=1, err_cnt=0.
REQ-033 Bench SHALL check: model bit 3 of address 5 stuck-at-1 -> pass=0 and err_cnt=1; with MEM_BIST_FAIL_LOG_EN, fail_addr=5 and fail_data=(8'h05^8'hA5)|8'h08=8'hA8.
REQ-034 Bench SHALL check: RD_LAT=3 with a 3-cycle model, fault-free -> busy for 71 cycles, pass=1.
REQ-035 Bench SHALL check: start re-pulsed at busy cycle 10 -> ignored; exactly one done pulse.
REQ-036 Bench SHALL check: rst_n low at busy cycle 20 -> next cycle busy=0, mem_we=0, no done pulse; a fresh start then completes with pass=1.
REQ-037 Bench SHALL check: every address stuck-at-0 model -> err_cnt=32 (D per pass x 2), pass=0.
